// File: rtl/mat_ops_pkg.sv
// mat_ops_pkg
//   Shared definitions for the streaming matrix operation unit:
//   operation codes, error codes, the controller state encoding and the
//   output-width helpers used by the MAC saturation stage.
//   The helpers take a 64-bit sign-extended value plus the target element
//   width so a single function body serves any DATA_W/ACC_W combination
//   (the caller sign-extends its ACC_W accumulator to 64 bits first).
package mat_ops_pkg;

  // Operation select encoding (op_sel)
  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_SCALAR    = 3'b010;
  localparam logic [2:0] OP_MUL       = 3'b011;
  localparam logic [2:0] OP_CONV      = 3'b100;
  localparam logic [2:0] OP_SUB       = 3'b101;

  // Error codes reported on error_code
  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_BAD_DIM    = 2'b01;
  localparam logic [1:0] ERR_MISMATCH   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'b11;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_CALC  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Reduce a wide signed value to the data_w signed range: clamp when sat
  // is set, otherwise keep the low data_w bits (returned sign-extended).
  function automatic logic signed [63:0] clamp_val(input logic signed [63:0] v,
                                                   input int data_w,
                                                   input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat) begin
      if (v > hi) begin
        res = hi;
      end else if (v < lo) begin
        res = lo;
      end else begin
        res = v;
      end
    end else begin
      res = (v <<< (64 - data_w)) >>> (64 - data_w);
    end
    return res;
  endfunction

  // True when v does not fit the data_w signed range.
  function automatic logic is_ovf(input logic signed [63:0] v, input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/mat_ops_stream_mac.sv
// mat_mac_sat
//   Signed multiply-accumulate with clear/enable/load and a saturating or
//   wrapping output stage.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     clr, en         en accumulates mul_a*mul_b; with clr the old sum is dropped
//     load, load_val  overwrite the accumulator (element-wise ops)
//     mul_a, mul_b    signed DATA_W operands
//     sat_mode        1 = clamp, 0 = wrap
//     sat_data        next accumulator value reduced to DATA_W
//     sat_ovf         next accumulator value lies outside the DATA_W range
//   The output stage looks at the value being written this cycle, so the
//   caller can register the finished element on the same edge that
//   completes the accumulation.
module mat_mac_sat
  import mat_ops_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W + 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     load,
  input  logic signed [ACC_W-1:0]  load_val,
  input  logic signed [DATA_W-1:0] mul_a,
  input  logic signed [DATA_W-1:0] mul_b,
  input  logic                     sat_mode,
  output logic signed [DATA_W-1:0] sat_data,
  output logic                     sat_ovf
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [63:0]         acc_wide;

  assign a_ext    = {{DATA_W{mul_a[DATA_W-1]}}, mul_a};
  assign b_ext    = {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Next accumulator value: load wins, clr restarts the running sum.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (en) begin
      acc_d = (clr ? '0 : acc_q) + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_wide = {{(64-ACC_W){acc_d[ACC_W-1]}}, acc_d};
  assign sat_data = DATA_W'(clamp_val(acc_wide, DATA_W, sat_mode));
  assign sat_ovf  = is_ovf(acc_wide, DATA_W);

endmodule

// File: rtl/mat_ops_stream.sv
// mat_ops_stream
//   Streaming matrix operation unit. Snapshots two row-major operand
//   matrices on start_op, checks legality, then computes transpose, add,
//   subtract, scalar multiply, matrix multiply or valid 2-D correlation one
//   element at a time and streams the results out over valid/ready.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     start_op, op_sel, sat_mode  request, operation, clamp(1)/wrap(0)
//     matrix_a_flat/_b_flat       operands, element (r,c) at index r*n+c
//     dim_a_m/_n, dim_b_m/_n      operand dimensions
//     scalar_k                    signed scalar for the scalar op
//     res_valid/res_ready         result stream handshake
//     res_data, res_last          element and final-element marker
//     result_m, result_n          result dimensions while busy
//     busy, op_done               activity, one-cycle completion pulse
//     error_flag, error_code      rejected request and reason
//     ovf_flag                    some element of this op was clamped/wrapped
module mat_ops_stream
  import mat_ops_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int ACC_W   = 2 * DATA_W + 5,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_op,
  input  logic [2:0]                        op_sel,
  input  logic                              sat_mode,
  input  logic [DATA_W*MAX_DIM*MAX_DIM-1:0] matrix_a_flat,
  input  logic [DATA_W*MAX_DIM*MAX_DIM-1:0] matrix_b_flat,
  input  logic [DIM_W-1:0]                  dim_a_m,
  input  logic [DIM_W-1:0]                  dim_a_n,
  input  logic [DIM_W-1:0]                  dim_b_m,
  input  logic [DIM_W-1:0]                  dim_b_n,
  input  logic signed [DATA_W-1:0]          scalar_k,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic signed [DATA_W-1:0]          res_data,
  output logic                              res_last,
  output logic [DIM_W-1:0]                  result_m,
  output logic [DIM_W-1:0]                  result_n,
  output logic                              busy,
  output logic                              op_done,
  output logic                              error_flag,
  output logic [1:0]                        error_code,
  output logic                              ovf_flag
);

  localparam int NEL   = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NEL + 1);
  localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  state_t state_q, state_d;

  // Snapshot of the accepted request
  logic [2:0]                        op_q;
  logic                              sat_q;
  logic signed [DATA_W-1:0]          k_q;
  logic [DATA_W*NEL-1:0]             a_q, b_q;
  logic [DIM_W-1:0]                  a_m_q, a_n_q, b_m_q, b_n_q;

  // Element position and inner (multiply) / kernel (conv) counters
  logic [DIM_W-1:0]                  row_q, col_q, kk_q, kr_q, kc_q;

  logic [DIM_W-1:0]                  result_m_q, result_n_q;
  logic signed [DATA_W-1:0]          res_data_q;
  logic                              res_last_q;
  logic [1:0]                        err_code_q;
  logic                              ovf_q;

  logic [1:0]                        chk_code;
  logic [DIM_W-1:0]                  calc_m, calc_n;
  logic                              calc_last;

  logic signed [DATA_W-1:0]          a_el [NEL];
  logic signed [DATA_W-1:0]          b_el [NEL];
  logic [IDX_W-1:0]                  a_idx, b_idx;
  logic [DIM_W-1:0]                  conv_r, conv_c;
  logic signed [DATA_W-1:0]          a_sel, b_sel;

  logic                              mac_clr, mac_en, mac_load;
  logic signed [ACC_W-1:0]           mac_load_val;
  logic signed [DATA_W-1:0]          mac_a, mac_b;
  logic signed [DATA_W-1:0]          mac_sat_data;
  logic                              mac_sat_ovf;

  function automatic logic [IDX_W-1:0] elem_idx(input logic [DIM_W-1:0] r,
                                                input logic [DIM_W-1:0] c,
                                                input logic [DIM_W-1:0] n);
    return IDX_W'(r) * IDX_W'(n) + IDX_W'(c);
  endfunction

  function automatic logic signed [ACC_W-1:0] to_acc(input logic signed [DATA_W-1:0] x);
    return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_MAX);
  endfunction

  // Unpack the latched operands so elements can be picked by index.
  always_comb begin
    for (int i = 0; i < NEL; i++) begin
      a_el[i] = a_q[i*DATA_W +: DATA_W];
      b_el[i] = b_q[i*DATA_W +: DATA_W];
    end
  end

  // Legality checks in priority order: op code, used dimensions, shape match.
  always_comb begin
    chk_code = ERR_NONE;
    if (op_q > OP_SUB) begin
      chk_code = ERR_ILLEGAL_OP;
    end else if (!dim_ok(a_m_q) || !dim_ok(a_n_q) ||
                 ((op_q != OP_TRANSPOSE) && (op_q != OP_SCALAR) &&
                  (!dim_ok(b_m_q) || !dim_ok(b_n_q)))) begin
      chk_code = ERR_BAD_DIM;
    end else begin
      case (op_q)
        OP_ADD, OP_SUB: if ((a_m_q != b_m_q) || (a_n_q != b_n_q)) chk_code = ERR_MISMATCH;
        OP_MUL:         if (a_n_q != b_m_q) chk_code = ERR_MISMATCH;
        OP_CONV:        if ((b_m_q > a_m_q) || (b_n_q > a_n_q)) chk_code = ERR_MISMATCH;
        default:        chk_code = ERR_NONE;
      endcase
    end
  end

  // Result shape for each operation.
  always_comb begin
    calc_m = a_m_q;
    calc_n = a_n_q;
    case (op_q)
      OP_TRANSPOSE: begin calc_m = a_n_q; calc_n = a_m_q; end
      OP_MUL:       begin calc_m = a_m_q; calc_n = b_n_q; end
      OP_CONV: begin
        calc_m = a_m_q - b_m_q + DIM_ONE;
        calc_n = a_n_q - b_n_q + DIM_ONE;
      end
      default: begin calc_m = a_m_q; calc_n = a_n_q; end
    endcase
  end

  assign conv_r = row_q + kr_q;
  assign conv_c = col_q + kc_q;

  // Operand element addressing for the current output position.
  // Transpose reads A with row/col swapped; conv slides the kernel window.
  always_comb begin
    a_idx = elem_idx(row_q, col_q, a_n_q);
    b_idx = elem_idx(row_q, col_q, b_n_q);
    case (op_q)
      OP_TRANSPOSE: a_idx = elem_idx(col_q, row_q, a_n_q);
      OP_MUL: begin
        a_idx = elem_idx(row_q, kk_q, a_n_q);
        b_idx = elem_idx(kk_q, col_q, b_n_q);
      end
      OP_CONV: begin
        a_idx = elem_idx(conv_r, conv_c, a_n_q);
        b_idx = elem_idx(kr_q, kc_q, b_n_q);
      end
      default: begin
        a_idx = elem_idx(row_q, col_q, a_n_q);
        b_idx = elem_idx(row_q, col_q, b_n_q);
      end
    endcase
  end

  assign a_sel = a_el[a_idx];
  assign b_sel = b_el[b_idx];

  // MAC control. Element-wise ops load their value in one cycle; the
  // scalar op is a single cleared MAC; multiply and conv clear on their
  // first inner step and accumulate until the last one.
  always_comb begin
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    mac_load     = 1'b0;
    mac_load_val = '0;
    mac_a        = a_sel;
    mac_b        = b_sel;
    calc_last    = 1'b0;
    if (state_q == ST_CALC) begin
      case (op_q)
        OP_TRANSPOSE: begin
          mac_load = 1'b1; mac_load_val = to_acc(a_sel); calc_last = 1'b1;
        end
        OP_ADD: begin
          mac_load = 1'b1; mac_load_val = to_acc(a_sel) + to_acc(b_sel); calc_last = 1'b1;
        end
        OP_SUB: begin
          mac_load = 1'b1; mac_load_val = to_acc(a_sel) - to_acc(b_sel); calc_last = 1'b1;
        end
        OP_SCALAR: begin
          mac_en = 1'b1; mac_clr = 1'b1; mac_b = k_q; calc_last = 1'b1;
        end
        OP_MUL: begin
          mac_en    = 1'b1;
          mac_clr   = (kk_q == '0);
          calc_last = (kk_q == a_n_q - DIM_ONE);
        end
        OP_CONV: begin
          mac_en    = 1'b1;
          mac_clr   = (kr_q == '0) && (kc_q == '0);
          calc_last = (kr_q == b_m_q - DIM_ONE) && (kc_q == b_n_q - DIM_ONE);
        end
        default: calc_last = 1'b1;
      endcase
    end
  end

  mat_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .load     (mac_load),
    .load_val (mac_load_val),
    .mul_a    (mac_a),
    .mul_b    (mac_b),
    .sat_mode (sat_q),
    .sat_data (mac_sat_data),
    .sat_ovf  (mac_sat_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    res_valid  = 1'b0;
    busy       = 1'b1;
    op_done    = 1'b0;
    error_flag = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_op) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = (chk_code == ERR_NONE) ? ST_CALC : ST_ERR;
      ST_CALC:  if (calc_last) state_d = ST_EMIT;
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = res_last_q ? ST_DONE : ST_CALC;
      end
      ST_DONE: begin
        op_done = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        op_done    = 1'b1;
        error_flag = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request snapshot, counters, output register and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      sat_q      <= 1'b0;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_m_q      <= '0;
      a_n_q      <= '0;
      b_m_q      <= '0;
      b_n_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      kk_q       <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      result_m_q <= '0;
      result_n_q <= '0;
      res_data_q <= '0;
      res_last_q <= 1'b0;
      err_code_q <= ERR_NONE;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_op) begin
            op_q       <= op_sel;
            sat_q      <= sat_mode;
            k_q        <= scalar_k;
            a_q        <= matrix_a_flat;
            b_q        <= matrix_b_flat;
            a_m_q      <= dim_a_m;
            a_n_q      <= dim_a_n;
            b_m_q      <= dim_b_m;
            b_n_q      <= dim_b_n;
            err_code_q <= ERR_NONE;
            ovf_q      <= 1'b0;
          end
        end
        ST_CHECK: begin
          row_q      <= '0;
          col_q      <= '0;
          kk_q       <= '0;
          kr_q       <= '0;
          kc_q       <= '0;
          err_code_q <= chk_code;
          if (chk_code == ERR_NONE) begin
            result_m_q <= calc_m;
            result_n_q <= calc_n;
          end else begin
            result_m_q <= '0;
            result_n_q <= '0;
          end
        end
        ST_CALC: begin
          if (calc_last) begin
            res_data_q <= mac_sat_data;
            res_last_q <= (row_q == result_m_q - DIM_ONE) && (col_q == result_n_q - DIM_ONE);
            ovf_q      <= ovf_q | mac_sat_ovf;
            kk_q       <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
          end else if (op_q == OP_MUL) begin
            kk_q <= kk_q + DIM_ONE;
          end else if (kc_q == b_n_q - DIM_ONE) begin
            kc_q <= '0;
            kr_q <= kr_q + DIM_ONE;
          end else begin
            kc_q <= kc_q + DIM_ONE;
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            if (col_q == result_n_q - DIM_ONE) begin
              col_q <= '0;
              row_q <= row_q + DIM_ONE;
            end else begin
              col_q <= col_q + DIM_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign res_data   = res_data_q;
  assign res_last   = res_last_q;
  assign result_m   = result_m_q;
  assign result_n   = result_n_q;
  assign error_code = err_code_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_mat_ops_stream.sv
// tb_mat_ops_stream
//   Drives directed and randomized requests into mat_ops_stream and compares
//   the collected result stream and status against a matrix-arithmetic
//   reference model.
module tb_mat_ops_stream;

  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int NEL     = MAX_DIM * MAX_DIM;
  localparam int DIM_W   = 3;
  localparam int ACC_W   = 2 * DATA_W + 5;

  logic                     clk;
  logic                     rst_n;
  logic                     start_op;
  logic [2:0]               op_sel;
  logic                     sat_mode;
  logic [DATA_W*NEL-1:0]    matrix_a_flat;
  logic [DATA_W*NEL-1:0]    matrix_b_flat;
  logic [DIM_W-1:0]         dim_a_m, dim_a_n, dim_b_m, dim_b_n;
  logic signed [DATA_W-1:0] scalar_k;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [DATA_W-1:0] res_data;
  logic                     res_last;
  logic [DIM_W-1:0]         result_m, result_n;
  logic                     busy, op_done, error_flag, ovf_flag;
  logic [1:0]               error_code;

  mat_ops_stream #(
    .DATA_W  (DATA_W),
    .MAX_DIM (MAX_DIM),
    .ACC_W   (ACC_W),
    .DIM_W   (DIM_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_op      (start_op),
    .op_sel        (op_sel),
    .sat_mode      (sat_mode),
    .matrix_a_flat (matrix_a_flat),
    .matrix_b_flat (matrix_b_flat),
    .dim_a_m       (dim_a_m),
    .dim_a_n       (dim_a_n),
    .dim_b_m       (dim_b_m),
    .dim_b_n       (dim_b_n),
    .scalar_k      (scalar_k),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_last      (res_last),
    .result_m      (result_m),
    .result_n      (result_n),
    .busy          (busy),
    .op_done       (op_done),
    .error_flag    (error_flag),
    .error_code    (error_code),
    .ovf_flag      (ovf_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;
  int ma [NEL];
  int mb [NEL];
  int expQ [$];
  int expCode, expM, expN, expK;
  bit expOvf;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int fitVal(input longint v, input bit sat);
    longint hi, lo, span, w;
    hi   = (longint'(1) <<< (DATA_W - 1)) - 1;
    lo   = -hi - 1;
    span = longint'(1) <<< DATA_W;
    if (sat) return int'((v > hi) ? hi : ((v < lo) ? lo : v));
    w = v % span;
    if (w < 0) w += span;
    if (w > hi) w -= span;
    return int'(w);
  endfunction

  function automatic bit outOfRange(input longint v);
    longint hi;
    hi = (longint'(1) <<< (DATA_W - 1)) - 1;
    return (v > hi) || (v < -hi - 1);
  endfunction

  function automatic bit dimBad(input int d);
    return (d < 1) || (d > MAX_DIM);
  endfunction

  // Reference: plain matrix arithmetic over ma/mb, row-major results.
  task automatic buildExpected(input int op, input int am, input int an, input int bm,
                               input int bn, input int k, input bit sat);
    longint v;
    int rm, rn;
    expQ.delete();
    expOvf = 0;
    expCode = 0;
    if (op > 5) expCode = 3;
    else if (dimBad(am) || dimBad(an) ||
             (op != 0 && op != 2 && (dimBad(bm) || dimBad(bn)))) expCode = 1;
    else if ((op == 1 || op == 5) && (am != bm || an != bn)) expCode = 2;
    else if (op == 3 && an != bm) expCode = 2;
    else if (op == 4 && (bm > am || bn > an)) expCode = 2;
    expK = (op == 3) ? an : ((op == 4) ? bm * bn : 1);
    expM = 0;
    expN = 0;
    if (expCode != 0) return;
    case (op)
      0:       begin rm = an; rn = am; end
      3:       begin rm = am; rn = bn; end
      4:       begin rm = am - bm + 1; rn = an - bn + 1; end
      default: begin rm = am; rn = an; end
    endcase
    expM = rm;
    expN = rn;
    for (int r = 0; r < rm; r++) begin
      for (int c = 0; c < rn; c++) begin
        v = 0;
        case (op)
          0: v = ma[c * an + r];
          1: v = ma[r * an + c] + mb[r * bn + c];
          2: v = longint'(ma[r * an + c]) * k;
          3: for (int i = 0; i < an; i++) v += longint'(ma[r * an + i]) * mb[i * bn + c];
          4: for (int i = 0; i < bm; i++)
               for (int j = 0; j < bn; j++)
                 v += longint'(ma[(r + i) * an + c + j]) * mb[i * bn + j];
          default: v = ma[r * an + c] - mb[r * bn + c];
        endcase
        if (outOfRange(v)) expOvf = 1;
        expQ.push_back(fitVal(v, sat));
      end
    end
  endtask

  function automatic logic [DATA_W*NEL-1:0] packMat(input int m [NEL]);
    logic [DATA_W*NEL-1:0] f;
    for (int i = 0; i < NEL; i++) f[i*DATA_W +: DATA_W] = m[i][DATA_W-1:0];
    return f;
  endfunction

  // Issue one request, scramble the inputs after acceptance, collect the
  // stream with random backpressure and compare everything at the end.
  task automatic applyStimulus(input int op, input int am, input int an, input int bm,
                               input int bn, input int k, input bit sat,
                               input int readyPct, input bit poke);
    int gotQ [$];
    bit lastQ [$];
    int cyc, firstValid, validSeen, doneCnt;
    bit finished, doneSeen, stall, heldLast, readyNow;
    int heldData;
    buildExpected(op, am, an, bm, bn, k, sat);
    @(negedge clk);
    op_sel        = op[2:0];
    dim_a_m       = am[DIM_W-1:0];
    dim_a_n       = an[DIM_W-1:0];
    dim_b_m       = bm[DIM_W-1:0];
    dim_b_n       = bn[DIM_W-1:0];
    scalar_k      = k[DATA_W-1:0];
    sat_mode      = sat;
    matrix_a_flat = packMat(ma);
    matrix_b_flat = packMat(mb);
    start_op      = 1'b1;
    res_ready     = 1'b0;
    @(posedge clk);
    #1;
    start_op      = poke;
    op_sel        = 3'($urandom_range(7));
    dim_a_m       = 3'($urandom_range(7));
    dim_a_n       = 3'($urandom_range(7));
    dim_b_m       = 3'($urandom_range(7));
    dim_b_n       = 3'($urandom_range(7));
    scalar_k      = 8'($urandom_range(255));
    sat_mode      = ~sat;
    matrix_a_flat = {7{$urandom}};
    matrix_b_flat = {7{$urandom}};
    cyc = 0; firstValid = -1; validSeen = 0; doneCnt = 0;
    finished = 0; doneSeen = 0; stall = 0; heldData = 0; heldLast = 0;
    while (!finished && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        validSeen++;
        if (firstValid < 0) begin
          firstValid = cyc;
          checkOutput("result_m", result_m, expM);
          checkOutput("result_n", result_n, expN);
        end
      end
      if (stall) begin
        checkOutput("stall_valid", res_valid, 1);
        checkOutput("stall_data", res_data, heldData);
        checkOutput("stall_last", res_last, heldLast);
      end
      if (doneSeen) begin
        checkOutput("busy_fall", busy, 0);
        checkOutput("done_pulse", op_done, 0);
        start_op = 1'b0;
        finished = 1;
      end else if (op_done) begin
        doneSeen = 1;
        checkOutput("busy_at_done", busy, 1);
        checkOutput("error_flag", error_flag, (expCode != 0) ? 1 : 0);
        checkOutput("error_code", error_code, expCode);
        checkOutput("ovf_flag", ovf_flag, expOvf);
        if (expCode != 0) begin
          checkOutput("err_result_m", result_m, 0);
          checkOutput("err_result_n", result_n, 0);
        end
      end
      readyNow  = ($urandom_range(99) < readyPct);
      res_ready = readyNow;
      if (res_valid && readyNow) begin
        gotQ.push_back(int'(res_data));
        lastQ.push_back(res_last);
        stall = 0;
      end else if (res_valid) begin
        stall    = 1;
        heldData = int'(res_data);
        heldLast = res_last;
      end else begin
        stall = 0;
      end
    end
    start_op  = 1'b0;
    res_ready = 1'b0;
    checkOutput("finished_in_budget", finished, 1);
    checkOutput("beat_count", gotQ.size(), expQ.size());
    if (expCode == 0) checkOutput("first_valid_cycle", firstValid, 2 + expK);
    else checkOutput("no_valid_on_error", validSeen, 0);
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("data[%0d]", i), gotQ[i], expQ[i]);
      checkOutput($sformatf("last[%0d]", i), lastQ[i], (i == expQ.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic fillSeq(input int first);
    for (int i = 0; i < NEL; i++) begin
      ma[i] = first + i;
      mb[i] = i + 1;
    end
  endtask

  initial begin
    int op, am, an, bm, bn, accepted;
    bit hit;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start_op = 1'b0;
    op_sel = '0;
    sat_mode = 1'b0;
    matrix_a_flat = '0;
    matrix_b_flat = '0;
    dim_a_m = '0; dim_a_n = '0; dim_b_m = '0; dim_b_n = '0;
    scalar_k = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", op_done, 0);
    checkOutput("rst_err", {error_flag, error_code, ovf_flag}, 0);
    checkOutput("rst_dims", {result_m, result_n}, 0);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    fillSeq(1);
    applyStimulus(0, 3, 2, 1, 1, 0, 1, 100, 0);
    applyStimulus(3, 2, 3, 3, 2, 0, 1, 50, 1);
    applyStimulus(2, 3, 3, 1, 1, -2, 1, 100, 0);
    applyStimulus(2, 3, 3, 1, 1, 100, 1, 70, 0);
    applyStimulus(2, 3, 3, 1, 1, 100, 0, 70, 1);
    applyStimulus(4, 3, 3, 2, 2, 0, 1, 60, 0);
    fillSeq(10);
    applyStimulus(5, 2, 2, 2, 2, 0, 1, 100, 0);
    fillSeq(1);
    applyStimulus(1, 2, 2, 3, 3, 0, 1, 100, 1);
    applyStimulus(7, 2, 2, 2, 2, 0, 1, 100, 0);
    applyStimulus(1, 0, 2, 2, 2, 0, 1, 100, 1);

    $display("[TB] reset during a multiply");
    @(negedge clk);
    op_sel = 3'b011;
    dim_a_m = 3'd2; dim_a_n = 3'd3; dim_b_m = 3'd3; dim_b_n = 3'd2;
    matrix_a_flat = packMat(ma);
    matrix_b_flat = packMat(mb);
    sat_mode = 1'b1;
    start_op = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start_op = 1'b0;
    accepted = 0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (res_valid) begin
        if (accepted == 1) hit = 1;
        else accepted++;
      end
    end
    checkOutput("reached_beat2", hit, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", res_valid, 0);
    checkOutput("abort_data", res_data, 0);
    checkOutput("abort_last", res_last, 0);
    checkOutput("abort_dims", {result_m, result_n}, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_status", {op_done, error_flag, error_code, ovf_flag}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_no_done", op_done, 0);
    end
    rst_n = 1'b1;
    res_ready = 1'b0;
    applyStimulus(0, 3, 2, 1, 1, 0, 1, 100, 0);

    $display("[TB] randomized operations");
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(5);
      am = $urandom_range(1, MAX_DIM);
      an = $urandom_range(1, MAX_DIM);
      bm = $urandom_range(1, MAX_DIM);
      bn = $urandom_range(1, MAX_DIM);
      if (op == 1 || op == 5) begin bm = am; bn = an; end
      if (op == 3) bm = an;
      if (op == 4) begin bm = $urandom_range(1, am); bn = $urandom_range(1, an); end
      if ($urandom_range(7) == 0) begin
        op = $urandom_range(7);
        am = $urandom_range(7); an = $urandom_range(7);
        bm = $urandom_range(7); bn = $urandom_range(7);
      end
      for (int i = 0; i < NEL; i++) begin
        ma[i] = int'($urandom_range(255)) - 128;
        mb[i] = int'($urandom_range(255)) - 128;
      end
      applyStimulus(op, am, an, bm, bn, int'($urandom_range(255)) - 128,
                    1'($urandom_range(1)), $urandom_range(30, 100), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
